// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port word RAM (byte write mask, 1-cycle read latency)
// between two bus masters: M0 (processor) and M1 (DMA / debug loader).
// At most one access is forwarded per cycle. Ties are broken round-robin,
// except that the master granted last may keep the RAM for a bounded burst
// while it holds its lock input high.
//
// The grant is combinational, so an uncontended request is acked and driven
// to the RAM in the same cycle. Read data is returned one cycle after the
// ack. It is broadcast to both masters, and only the owner's rvalid is raised.
//
// Parameters
//   MAX_BURST   maximum consecutive locked grants to one master while the
//               other master waits (1..15)
//
// Ports
//   clk                         system clock
//   RESET                       asynchronous, active-high reset
//   m0_addr / m1_addr           master byte address
//   m0_rstrb / m1_rstrb         master read request
//   m0_wdata / m1_wdata         master write data
//   m0_wmask / m1_wmask         master byte write mask (nonzero = write)
//   m0_lock / m1_lock           master asks to keep the grant next cycle
//   m0_ack / m1_ack             access issued this cycle
//   m0_rvalid / m1_rvalid       read data valid for this master
//   m0_rdata / m1_rdata         read data (broadcast copy of mem_rdata)
//   mem_addr                    address to RAM
//   mem_rstrb                   read strobe to RAM
//   mem_wdata                   write data to RAM
//   mem_wmask                   byte write mask to RAM
//   mem_rdata                   RAM read data, valid the cycle after mem_rstrb
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        RESET,

    input  logic [31:0] m0_addr,
    input  logic        m0_rstrb,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic        m0_lock,
    output logic        m0_ack,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic [31:0] m1_addr,
    input  logic        m1_rstrb,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wmask,
    input  logic        m1_lock,
    output logic        m1_ack,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic [31:0] mem_addr,
    output logic        mem_rstrb,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

    // Saturating increment of the locked-burst counter.
    function automatic logic [3:0] burst_inc(input logic [3:0] cnt);
        logic [3:0] res;
        if (cnt >= C_MAX_BURST) begin
            res = C_MAX_BURST;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic       r_last_grant;   // 0 = M0, 1 = M1 was granted most recently
    logic       r_lock_q;       // lock input of the last grantee
    logic [3:0] r_burst_cnt;    // consecutive locked grants to r_last_grant
    logic       r_rv_q;         // a read was issued in the previous cycle
    logic       r_rv_owner;     // master that owns the returning read

    // ------------------------------------------------------------------
    // Request decode and grant selection
    // ------------------------------------------------------------------
    logic w_req0;
    logic w_req1;
    logic w_gnt_any;    // some master is granted (before reset gating)
    logic w_gnt_sel;    // grantee: 0 = M0, 1 = M1
    logic w_issue;      // access actually forwarded this cycle
    logic w_sel_rstrb;  // read strobe of the grantee

    assign w_req0 = m0_rstrb | (|m0_wmask);
    assign w_req1 = m1_rstrb | (|m1_wmask);

    // Grant selection: single requester wins; on a tie the lock holder keeps
    // the RAM while its burst budget lasts, otherwise round-robin.
    // r_lock_q is only ever set by a grant in the immediately preceding cycle
    // (idle cycles clear it), so the lock holder is always r_last_grant.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_sel = 1'b0;
        if (w_req0 && w_req1) begin
            w_gnt_any = 1'b1;
            if (r_lock_q && (r_burst_cnt < C_MAX_BURST)) begin
                w_gnt_sel = r_last_grant;
            end else begin
                w_gnt_sel = ~r_last_grant;
            end
        end else if (w_req0) begin
            w_gnt_any = 1'b1;
            w_gnt_sel = 1'b0;
        end else if (w_req1) begin
            w_gnt_any = 1'b1;
            w_gnt_sel = 1'b1;
        end else begin
            w_gnt_any = 1'b0;
            w_gnt_sel = 1'b0;
        end
    end

    // Nothing may reach the RAM or the masters while reset is asserted.
    assign w_issue     = w_gnt_any & ~RESET;
    assign w_sel_rstrb = w_gnt_sel ? m1_rstrb : m0_rstrb;

    assign m0_ack = w_issue & ~w_gnt_sel;
    assign m1_ack = w_issue &  w_gnt_sel;

    // RAM-side mux: the granted master drives the RAM; when idle, M0's
    // address and data pass through with both strobes forced low.
    always_comb begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_rstrb = 1'b0;
        mem_wmask = 4'b0000;
        if (w_issue && w_gnt_sel) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_rstrb = m1_rstrb;
            mem_wmask = m1_wmask;
        end else if (w_issue) begin
            mem_rstrb = m0_rstrb;
            mem_wmask = m0_wmask;
        end else begin
            mem_rstrb = 1'b0;
            mem_wmask = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration state update
    // ------------------------------------------------------------------
    // Round-robin pointer, lock capture and burst counter. An idle cycle
    // breaks any burst: the counter and the captured lock are cleared so a
    // later tie falls back to plain round-robin.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_last_grant <= 1'b1;
            r_lock_q     <= 1'b0;
            r_burst_cnt  <= 4'd0;
        end else if (w_gnt_any) begin
            r_last_grant <= w_gnt_sel;
            r_lock_q     <= w_gnt_sel ? m1_lock : m0_lock;
            if ((w_gnt_sel == r_last_grant) && r_lock_q) begin
                r_burst_cnt <= burst_inc(r_burst_cnt);
            end else begin
                r_burst_cnt <= 4'd0;
            end
        end else begin
            r_last_grant <= r_last_grant;
            r_lock_q     <= 1'b0;
            r_burst_cnt  <= 4'd0;
        end
    end

    // ------------------------------------------------------------------
    // Read return tagging
    // ------------------------------------------------------------------
    // Remembers whether the access issued this cycle was a read, and for
    // whom, so the RAM data next cycle is qualified for the right master.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_rv_q     <= 1'b0;
            r_rv_owner <= 1'b0;
        end else if (w_gnt_any) begin
            r_rv_q     <= w_sel_rstrb;
            r_rv_owner <= w_gnt_sel;
        end else begin
            r_rv_q     <= 1'b0;
            r_rv_owner <= r_rv_owner;
        end
    end

    assign m0_rvalid = r_rv_q & ~r_rv_owner;
    assign m1_rvalid = r_rv_q &  r_rv_owner;
    assign m0_rdata  = mem_rdata;
    assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for mem_arbiter.
// A behavioural RAM model is attached to the mem_* port. A separate reference
// model of the arbitration rules and of the memory contents predicts grants,
// the RAM-side mux and read returns. Predicted reads go into a scoreboard
// queue at issue time and are popped one cycle later against m0/m1_rvalid.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk;
    logic        RESET;
    logic [31:0] m0_addr,  m1_addr;
    logic        m0_rstrb, m1_rstrb;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_lock,  m1_lock;
    logic        m0_ack,   m1_ack;
    logic        m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rstrb;
    logic [3:0]  mem_wmask;

    mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .RESET(RESET),
        .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_lock(m0_lock), .m0_ack(m0_ack),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_lock(m1_lock), .m1_ack(m1_ack),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: 64 words, byte mask, 1-cycle read latency.
    logic [31:0] ram [0:63];
    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
        for (int b = 0; b < 4; b++) begin
            if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] exp_mem [0:63];
    bit          md_last;
    bit          md_lock;
    int          md_cnt;
    bit          exp_any;
    bit          exp_sel;

    typedef struct {
        bit          owner;
        logic [31:0] data;
    } rd_t;
    rd_t rdq[$];

    int n_chk;
    int n_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_m(input bit m, input logic rs, input logic [3:0] wm,
                         input logic [31:0] a, input logic [31:0] wd, input logic lk);
        if (m) begin
            m1_rstrb = rs; m1_wmask = wm; m1_addr = a; m1_wdata = wd; m1_lock = lk;
        end else begin
            m0_rstrb = rs; m0_wmask = wm; m0_addr = a; m0_wdata = wd; m0_lock = lk;
        end
    endtask

    task automatic set_idle();
        set_m(1'b0, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        set_m(1'b1, 1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    endtask

    // Predict the grant for the current inputs from the model state.
    task automatic predict();
        bit r0, r1;
        r0 = m0_rstrb | (|m0_wmask);
        r1 = m1_rstrb | (|m1_wmask);
        exp_any = 1'b0;
        exp_sel = 1'b0;
        if (r0 && r1) begin
            exp_any = 1'b1;
            exp_sel = (md_lock && (md_cnt < MAX_BURST)) ? md_last : !md_last;
        end else if (r0) begin
            exp_any = 1'b1;
        end else if (r1) begin
            exp_any = 1'b1;
            exp_sel = 1'b1;
        end
    endtask

    // Mid-cycle checks: read return from the scoreboard, then this cycle's grant.
    task automatic check_phase();
        rd_t         e;
        logic [31:0] ga, gd;
        logic        gr;
        logic [3:0]  gm;
        @(negedge clk);
        if (rdq.size() > 0) begin
            e = rdq.pop_front();
            check_eq("m0_rvalid", m0_rvalid, {31'd0, !e.owner});
            check_eq("m1_rvalid", m1_rvalid, {31'd0, e.owner});
            check_eq(e.owner ? "m1_rdata" : "m0_rdata", e.owner ? m1_rdata : m0_rdata, e.data);
        end else begin
            check_eq("m0_rvalid_idle", m0_rvalid, 32'd0);
            check_eq("m1_rvalid_idle", m1_rvalid, 32'd0);
        end
        if (RESET) begin
            exp_any = 1'b0;
            exp_sel = 1'b0;
            check_eq("rst_m0_ack", m0_ack, 32'd0);
            check_eq("rst_m1_ack", m1_ack, 32'd0);
            check_eq("rst_mem_rstrb", mem_rstrb, 32'd0);
            check_eq("rst_mem_wmask", mem_wmask, 32'd0);
        end else begin
            predict();
            check_eq("m0_ack", m0_ack, {31'd0, exp_any && !exp_sel});
            check_eq("m1_ack", m1_ack, {31'd0, exp_any && exp_sel});
            ga = (exp_any && exp_sel) ? m1_addr  : m0_addr;
            gd = (exp_any && exp_sel) ? m1_wdata : m0_wdata;
            gr = exp_any ? (exp_sel ? m1_rstrb : m0_rstrb) : 1'b0;
            gm = exp_any ? (exp_sel ? m1_wmask : m0_wmask) : 4'b0000;
            check_eq("mem_addr", mem_addr, ga);
            check_eq("mem_wdata", mem_wdata, gd);
            check_eq("mem_rstrb", mem_rstrb, {31'd0, gr});
            check_eq("mem_wmask", mem_wmask, {28'd0, gm});
            if (exp_any && gr) begin
                e.owner = exp_sel;
                e.data  = exp_mem[ga[7:2]];
                rdq.push_back(e);
            end
        end
    endtask

    // Clock edge: advance the reference model exactly as the spec describes.
    task automatic commit();
        logic [31:0] a, d;
        logic [3:0]  wm;
        @(posedge clk);
        if (RESET) begin
            md_last = 1'b1; md_lock = 1'b0; md_cnt = 0;
            rdq.delete();
        end else if (exp_any) begin
            a  = exp_sel ? m1_addr  : m0_addr;
            d  = exp_sel ? m1_wdata : m0_wdata;
            wm = exp_sel ? m1_wmask : m0_wmask;
            for (int b = 0; b < 4; b++) begin
                if (wm[b]) exp_mem[a[7:2]][8*b +: 8] = d[8*b +: 8];
            end
            if ((exp_sel == md_last) && md_lock) md_cnt = (md_cnt >= MAX_BURST) ? MAX_BURST : md_cnt + 1;
            else md_cnt = 0;
            md_lock = exp_sel ? m1_lock : m0_lock;
            md_last = exp_sel;
        end else begin
            md_cnt  = 0;
            md_lock = 1'b0;
        end
        #1;
    endtask

    task automatic run_cycle();
        check_phase();
        commit();
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        set_idle();
        run_cycle();
        RESET = 1'b0;
    endtask

    initial begin
        logic [31:0] a0, a1, w;
        int          run_m1, done_m1;
        bit          m0_seen, m0_pend;

        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            ram[i] = w;
            exp_mem[i] = w;
        end
        ram[4] = 32'hDEAD_BEEF;
        exp_mem[4] = 32'hDEAD_BEEF;
        md_last = 1'b1; md_lock = 1'b0; md_cnt = 0;

        // Reset with requests present: nothing may be acked or strobed.
        RESET = 1'b1;
        set_m(1'b0, 1'b1, 4'b0000, 32'h0000_0010, 32'h0, 1'b0);
        set_m(1'b1, 1'b0, 4'b1111, 32'h0000_0020, 32'h1234_5678, 1'b0);
        #2;
        run_cycle();
        run_cycle();
        RESET = 1'b0;

        // M0 alone reads 0x10 (RAM[4]).
        set_idle();
        set_m(1'b0, 1'b1, 4'b0000, 32'h0000_0010, 32'h0, 1'b0);
        run_cycle();
        set_idle();
        check_phase();
        check_eq("deadbeef_return", m0_rdata, 32'hDEAD_BEEF);
        commit();
        run_cycle();

        // Both masters read continuously from reset: alternation M0, M1, ...
        apply_reset();
        a0 = 32'($urandom_range(0, 63)) << 2;
        a1 = 32'($urandom_range(0, 63)) << 2;
        for (int c = 0; c < 10; c++) begin
            set_m(1'b0, 1'b1, 4'b0000, a0, 32'h0, 1'b0);
            set_m(1'b1, 1'b1, 4'b0000, a1, 32'h0, 1'b0);
            check_phase();
            check_eq("rr_alternate_m0", m0_ack, {31'd0, (c % 2) == 0});
            if (exp_any && !exp_sel) a0 = 32'($urandom_range(0, 63)) << 2;
            if (exp_any &&  exp_sel) a1 = 32'($urandom_range(0, 63)) << 2;
            commit();
        end
        set_idle();
        run_cycle();

        // M1 locked burst of 10 writes while M0 wants one read.
        apply_reset();
        done_m1 = 0; run_m1 = 0; m0_seen = 1'b0; m0_pend = 1'b0;
        for (int c = 0; c < 30 && (done_m1 < 10 || m0_pend); c++) begin
            if (done_m1 < 10) set_m(1'b1, 1'b0, 4'b1111, 32'h40 + 32'(done_m1 * 4), $urandom, 1'b1);
            else set_m(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
            if (c == 1) m0_pend = 1'b1;
            if (m0_pend) set_m(1'b0, 1'b1, 4'b0000, 32'h0000_0044, 32'h0, 1'b0);
            else set_m(1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0);
            check_phase();
            if (m1_ack && !m0_seen) run_m1++;
            if (m0_ack) m0_seen = 1'b1;
            if (exp_any && exp_sel) done_m1++;
            if (exp_any && !exp_sel) m0_pend = 1'b0;
            commit();
        end
        check_eq("locked_run_len", run_m1, 32'(MAX_BURST + 1));
        check_eq("locked_m0_served", {31'd0, m0_seen}, 32'd1);
        set_idle();
        run_cycle();

        // Byte write by M1 then immediate read of the same word by M0.
        set_idle();
        set_m(1'b1, 1'b0, 4'b0001, 32'h0000_0020, 32'h0000_00AB, 1'b0);
        run_cycle();
        set_idle();
        set_m(1'b0, 1'b1, 4'b0000, 32'h0000_0020, 32'h0, 1'b0);
        run_cycle();
        set_idle();
        check_phase();
        check_eq("byte_write_lsb", {24'd0, m0_rdata[7:0]}, 32'h0000_00AB);
        commit();

        // Combined read+write: old data returned, new data visible next read.
        set_m(1'b0, 1'b1, 4'b1111, 32'h0000_0030, 32'hCAFE_F00D, 1'b0);
        run_cycle();
        set_m(1'b0, 1'b1, 4'b0000, 32'h0000_0030, 32'h0, 1'b0);
        run_cycle();
        set_idle();
        check_phase();
        check_eq("combined_new_data", m0_rdata, 32'hCAFE_F00D);
        commit();

        // Reset asserted mid-cycle after an M0 read ack: no rvalid follows.
        set_m(1'b0, 1'b1, 4'b0000, 32'h0000_0010, 32'h0, 1'b0);
        check_phase();
        #2;
        RESET = 1'b1;
        commit();
        set_m(1'b1, 1'b1, 4'b0000, 32'h0000_0014, 32'h0, 1'b0);
        run_cycle();
        RESET = 1'b0;
        check_phase();
        check_eq("post_reset_tie_m0", m0_ack, 32'd1);
        commit();
        set_idle();
        run_cycle();
        run_cycle();

        // Locked M1 burst, 3 idle cycles, then a tie: M0 must win.
        for (int c = 0; c < 3; c++) begin
            set_m(1'b1, 1'b0, 4'b1111, 32'h0000_0080 + 32'(c * 4), $urandom, 1'b1);
            run_cycle();
        end
        set_idle();
        for (int c = 0; c < 3; c++) run_cycle();
        set_m(1'b0, 1'b1, 4'b0000, 32'h0000_0008, 32'h0, 1'b0);
        set_m(1'b1, 1'b1, 4'b0000, 32'h0000_000C, 32'h0, 1'b1);
        check_phase();
        check_eq("after_idle_tie_m0", m0_ack, 32'd1);
        commit();
        run_cycle();
        set_idle();
        run_cycle();
        run_cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
